// File: rtl/seg_disp_pkg.sv
// Shared constants and types for the 7-segment display blocks.
package seg_disp_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 8;

  localparam logic [SEG_W-1:0]      SEG_OFF = 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = 4'b1111;

  // Hex nibble to segments g..a, active-high.
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    PH_ON    = 1'b0,
    PH_BLANK = 1'b1
  } phase_e;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to 7-segment (g..a) decoder.
module seg_hex_decoder
  import seg_disp_pkg::*;
(
  input  logic [NIB_W-1:0] nib,
  output logic [6:0]       seg7
);

  assign seg7 = HEX7_TABLE[nib];

endmodule

// File: rtl/seg_disp_arbiter.sv
// Two-requester round-robin arbiter feeding a tear-free 4-digit scanned display.
// Optional: define LEAD_ZERO_BLANK_EN to blank leading zero digits 3..1.
module seg_disp_arbiter
  import seg_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 125000,
  parameter int unsigned BLANK_CYC = 1250,
  parameter int unsigned CNT_W     = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [31:0]           req_data,
  output logic [1:0]            req_ready,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] dig,
  output logic                  owner,
  output logic                  frame_tick
);

  localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
  localparam int unsigned DATA_W = NIB_W * NUM_DIGITS;

  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK_CYC == 0) ? '0 : CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  // Last cycle of a digit slot is in BLANK unless blanking is disabled.
  localparam phase_e           LAST_PH    = (BLANK_CYC == 0) ? PH_ON : PH_BLANK;
  localparam logic [CNT_W-1:0] LAST_CNT   = (BLANK_CYC == 0) ? ON_LAST : BLANK_LAST;

  logic [IDX_W-1:0]  idx_q, idx_nxt;
  phase_e            phase_q, phase_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              tick_nxt;
  logic [DATA_W-1:0] disp_q, disp_nxt;
  logic              owner_nxt;
  logic [DATA_W-1:0] pend_buf_q, pend_buf_nxt;
  logic              pend_src_q, pend_src_nxt;
  logic              pend_full_q, pend_full_nxt;
  logic              rr_q, rr_nxt;

  logic              grant_a, grant_b;
  logic [1:0]        acc;
  logic [NIB_W-1:0]  nib;
  logic [6:0]        seg7;
  logic              lz_blank;

  // Round-robin grant; ready is withheld while the pending slot is occupied.
  assign grant_a   = req_valid[0] && (!req_valid[1] || !rr_q);
  assign grant_b   = req_valid[1] && (!req_valid[0] ||  rr_q);
  assign req_ready = {grant_b, grant_a} & {2{!pend_full_q}};
  assign acc       = req_valid & req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      phase_q     <= PH_ON;
      cnt_q       <= '0;
      frame_tick  <= 1'b0;
      disp_q      <= '0;
      owner       <= 1'b0;
      pend_buf_q  <= '0;
      pend_src_q  <= 1'b0;
      pend_full_q <= 1'b0;
      rr_q        <= 1'b0;
    end else begin
      idx_q       <= idx_nxt;
      phase_q     <= phase_nxt;
      cnt_q       <= cnt_nxt;
      frame_tick  <= tick_nxt;
      disp_q      <= disp_nxt;
      owner       <= owner_nxt;
      pend_buf_q  <= pend_buf_nxt;
      pend_src_q  <= pend_src_nxt;
      pend_full_q <= pend_full_nxt;
      rr_q        <= rr_nxt;
    end
  end

  // Scan sequencing; frame_tick is precomputed so it is high during the frame's last cycle.
  always_comb begin
    idx_nxt   = idx_q;
    phase_nxt = phase_q;
    cnt_nxt   = cnt_q + CNT_W'(1);
    if (phase_q == PH_ON) begin
      if (cnt_q == ON_LAST) begin
        cnt_nxt = '0;
        if (BLANK_CYC != 0) phase_nxt = PH_BLANK;
        else                idx_nxt   = idx_q + IDX_W'(1);
      end
    end else if (cnt_q == BLANK_LAST) begin
      cnt_nxt   = '0;
      phase_nxt = PH_ON;
      idx_nxt   = idx_q + IDX_W'(1);
    end
    tick_nxt = (idx_nxt == LAST_IDX) && (phase_nxt == LAST_PH) && (cnt_nxt == LAST_CNT);
  end

  // Pending buffer: accept when empty, commit to the display only at the frame boundary.
  always_comb begin
    disp_nxt      = disp_q;
    owner_nxt     = owner;
    pend_buf_nxt  = pend_buf_q;
    pend_src_nxt  = pend_src_q;
    pend_full_nxt = pend_full_q;
    rr_nxt        = rr_q;
    if (frame_tick && pend_full_q) begin
      disp_nxt      = pend_buf_q;
      owner_nxt     = pend_src_q;
      pend_full_nxt = 1'b0;
    end
    if (acc != 2'b00) begin
      pend_buf_nxt  = acc[1] ? req_data[31:16] : req_data[15:0];
      pend_src_nxt  = acc[1];
      pend_full_nxt = 1'b1;
      rr_nxt        = !acc[1];
    end
  end

  assign nib = NIB_W'(disp_q >> {idx_q, 2'b00});

`ifdef LEAD_ZERO_BLANK_EN
  assign lz_blank = (idx_q != '0) && ((disp_q >> {idx_q, 2'b00}) == '0);
`else
  assign lz_blank = 1'b0;
`endif

  seg_hex_decoder u_hex (
    .nib  (nib),
    .seg7 (seg7)
  );

  always_comb begin
    dig = DIG_OFF;
    seg = SEG_OFF;
    if (phase_q == PH_ON) begin
      dig      = ~(NUM_DIGITS'(1) << idx_q);
      seg[6:0] = lz_blank ? 7'h00 : seg7;
      seg[7]   = (idx_q == LAST_IDX) && owner;
    end
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Scoreboard bench for seg_disp_arbiter: frame-position reference model vs DUT outputs.
module tb_seg_disp_arbiter;

  localparam int unsigned SCAN  = 4;
  localparam int unsigned BLANK = 2;
  localparam int unsigned SLOT  = SCAN + BLANK;
  localparam int unsigned FRAME = 4 * SLOT;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [31:0] req_data;
  logic [1:0]  req_ready;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        owner;
  logic        frame_tick;

  seg_disp_arbiter #(
    .SCAN_DIV  (SCAN),
    .BLANK_CYC (BLANK),
    .CNT_W     (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .seg        (seg),
    .dig        (dig),
    .owner      (owner),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic [1:0] rdy;
    logic [3:0] dig;
    logic [7:0] seg;
    logic       own;
    logic       tick;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  logic [6:0] hex_ref [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: cycle position within the frame plus the logical buffers.
  int          m_t;
  logic [15:0] m_disp;
  logic        m_own;
  logic        m_pend;
  logic [15:0] m_pval;
  logic        m_psrc;
  logic        m_rr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void model_reset();
    m_t    = 0;
    m_disp = 16'h0000;
    m_own  = 1'b0;
    m_pend = 1'b0;
    m_pval = 16'h0000;
    m_psrc = 1'b0;
    m_rr   = 1'b0;
  endfunction

  function automatic logic [1:0] grant_ref(input logic [1:0] v);
    if (v == 2'b11) return m_rr ? 2'b10 : 2'b01;
    return v;
  endfunction

  function automatic exp_t expect_now(input logic [1:0] rdy);
    exp_t       e;
    int         p;
    int         d;
    logic [3:0] n;
    p      = m_t % FRAME;
    d      = p / SLOT;
    e.rdy  = rdy;
    e.own  = m_own;
    e.tick = (p == FRAME - 1);
    if ((p % SLOT) < SCAN) begin
      e.dig = ~(4'b0001 << d);
      n     = 4'((m_disp >> (4 * d)) & 16'h000F);
      e.seg = {(d == 3) ? m_own : 1'b0, hex_ref[n]};
`ifdef LEAD_ZERO_BLANK_EN
      if (d > 0 && (m_disp >> (4 * d)) == 16'h0000) e.seg[6:0] = 7'h00;
`endif
    end else begin
      e.dig = 4'b1111;
      e.seg = 8'h00;
    end
    return e;
  endfunction

  // Drive one cycle, queue its expected outputs, then advance the model across the edge.
  task automatic step(input logic rst_v, input logic [1:0] v, input logic [31:0] d,
                      output logic [1:0] acc);
    logic [1:0] rdy;
    @(negedge clk);
    rst_n     = rst_v;
    req_valid = v;
    req_data  = d;
    if (!rst_v) model_reset();
    rdy = m_pend ? 2'b00 : grant_ref(v);
    exp_q.push_back(expect_now(rdy));
    acc = rst_v ? (v & rdy) : 2'b00;
    if (rst_v) begin
      if ((m_t % FRAME) == FRAME - 1 && m_pend) begin
        m_disp = m_pval;
        m_own  = m_psrc;
        m_pend = 1'b0;
      end
      if (acc != 2'b00) begin
        m_pend = 1'b1;
        m_psrc = acc[1];
        m_pval = acc[1] ? d[31:16] : d[15:0];
        m_rr   = ~acc[1];
      end
      m_t = (m_t + 1) % FRAME;
    end
  endtask

  task automatic idle(input int n);
    logic [1:0] acc;
    repeat (n) step(1'b1, 2'b00, 32'h0, acc);
  endtask

  // Offer values until each offered requester has been accepted, within a cycle budget.
  task automatic offer(input logic [1:0] v0, input logic [31:0] d, input string name);
    logic [1:0] v;
    logic [1:0] acc;
    int         n;
    v = v0;
    n = 0;
    while (v != 2'b00 && n < 100) begin
      step(1'b1, v, d, acc);
      v = v & ~acc;
      n++;
    end
    tests++;
    if (v != 2'b00) begin
      fails++;
      $display("FAIL %s: still waiting=%b after %0d cycles, required none waiting", name, v, n);
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = '{rdy: req_ready, dig: dig, seg: seg, own: owner, tick: frame_tick};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL cycle @%0t: got rdy=%b dig=%b seg=%h own=%b tick=%b, required rdy=%b dig=%b seg=%h own=%b tick=%b",
                   $time, a.rdy, a.dig, a.seg, a.own, a.tick, e.rdy, e.dig, e.seg, e.own, e.tick);
        end
      end
    end
  end

  initial begin
    logic [1:0]  v;
    logic [31:0] d;
    logic [1:0]  acc;
    logic        r;
    rst_n     = 1'b0;
    req_valid = 2'b00;
    req_data  = 32'h0;
    model_reset();

    repeat (3) step(1'b0, 2'b00, 32'h0, acc);
    idle(2 * FRAME + 2);

    offer(2'b01, 32'h0000_12AF, "single_a");
    idle(2 * FRAME);

    offer(2'b11, {16'hBEEF, 16'h1234}, "both_valid");
    idle(2 * FRAME);

    offer(2'b01, 32'h0000_5A5A, "pend_before_reset");
    idle(5);
    repeat (2) step(1'b0, 2'b00, 32'h0, acc);
    idle(FRAME + 6);

    offer(2'b01, 32'h0000_0050, "lead_zero");
    idle(2 * FRAME);

    offer(2'b10, 32'h0007_0000, "single_b");
    idle(2 * FRAME);

    v = 2'b00;
    d = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      r = ($urandom_range(0, 599) != 0);
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          if ($urandom_range(0, 9) == 0) v[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          v[i] = 1'b1;
          d[16*i +: 16] = 16'($urandom) >> $urandom_range(0, 15);
        end
      end
      step(r, v, d, acc);
      v = v & ~acc;
    end

    idle(2);
    @(negedge clk);
    #5;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
